// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite write master.
package axil_pkg;

    typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B, DONE} wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_write_master_if.sv
// AXI4-Lite write-side channels (AW, W, B) between a master and a slave.
interface axil_write_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axil_valid_hold.sv
// Holds a channel's VALID from launch until its handshake; done is sticky until the next launch.
module axil_valid_hold (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic ready_i,
    output logic valid_o,
    output logic done_o
);

    logic valid_q;
    logic done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
        end
    end

    assign valid_o = valid_q;
    // Includes a handshake happening this cycle so the top can finish without a bubble.
    assign done_o  = done_q | (valid_q & ready_i);

endmodule

// File: rtl/axil_write_master.sv
// AXI4-Lite write-channel engine: launches one AW+W transfer per w_start and collects the B response.
module axil_write_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cntrl_rst,
    input  logic                    w_start,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    w_comp,
    output logic                    w_resp,
    output logic [1:0]              bresp_o,
    output logic                    wr_err,
    axil_write_master_if.master     axi
);

    wr_state_t               state_q;
    logic                    armed_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    bready_q;
    logic                    w_comp_q;
    logic                    w_resp_q;
    logic [1:0]              bresp_q;
    logic                    wr_err_q;

    logic launch;
    logic aw_done;
    logic w_done;
    logic timeout_hit;

    assign launch = (state_q == IDLE) && !cntrl_rst && w_start && armed_q;

    axil_valid_hold u_aw_hold (
        .clk     (clk),
        .reset   (reset),
        .set_i   (launch),
        .ready_i (axi.awready),
        .valid_o (axi.awvalid),
        .done_o  (aw_done)
    );

    axil_valid_hold u_w_hold (
        .clk     (clk),
        .reset   (reset),
        .set_i   (launch),
        .ready_i (axi.wready),
        .valid_o (axi.wvalid),
        .done_o  (w_done)
    );

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset || state_q != WAIT_B) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end

        assign timeout_hit = (state_q == WAIT_B) && (cnt_q == CntLast);
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            armed_q  <= 1'b1;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bready_q <= 1'b0;
            w_comp_q <= 1'b0;
            w_resp_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_err_q <= 1'b0;
        end else begin
            w_comp_q <= 1'b0;
            w_resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cntrl_rst) begin
                        armed_q <= 1'b1;
                    end else if (launch) begin
                        awaddr_q <= wr_addr;
                        wdata_q  <= wr_data;
                        wstrb_q  <= wr_strb;
                        bresp_q  <= RESP_OKAY;
                        wr_err_q <= 1'b0;
                        state_q  <= ADDR_DATA;
                    end else if (!w_start) begin
                        armed_q <= 1'b1;
                    end
                end
                ADDR_DATA: begin
                    if (aw_done && w_done) begin
                        w_comp_q <= 1'b1;
                        bready_q <= 1'b1;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A real response on the timeout cycle takes precedence.
                    if (axi.bvalid && bready_q) begin
                        bresp_q  <= axi.bresp;
                        wr_err_q <= (axi.bresp != RESP_OKAY);
                        w_resp_q <= 1'b1;
                        bready_q <= 1'b0;
                        state_q  <= DONE;
                    end else if (timeout_hit) begin
                        bresp_q  <= RESP_SLVERR;
                        wr_err_q <= 1'b1;
                        w_resp_q <= 1'b1;
                        bready_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    armed_q <= cntrl_rst;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.awaddr = awaddr_q;
    assign axi.awprot = 3'b000;
    assign axi.wdata  = wdata_q;
    assign axi.wstrb  = wstrb_q;
    assign axi.bready = bready_q;

    assign w_comp  = w_comp_q;
    assign w_resp  = w_resp_q;
    assign bresp_o = bresp_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_axil_write_master.sv
// Directed bench for axil_write_master with TIMEOUT_CYCLES=8.
module tb_axil_write_master;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cntrl_rst;
    logic        w_start;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        w_comp;
    logic        w_resp;
    logic [1:0]  bresp_o;
    logic        wr_err;

    int checks = 0;
    int errors = 0;
    int n_aw = 0, n_w = 0, n_comp = 0, n_both = 0;
    int aw0, w0, c0;

    axil_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axil_write_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cntrl_rst (cntrl_rst),
        .w_start   (w_start),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .w_comp    (w_comp),
        .w_resp    (w_resp),
        .bresp_o   (bresp_o),
        .wr_err    (wr_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    // Handshakes and pulses counted mid-cycle, where every signal is settled.
    always @(negedge clk) begin
        if (axi.awvalid && axi.awready) n_aw <= n_aw + 1;
        if (axi.wvalid && axi.wready) n_w <= n_w + 1;
        if (w_comp) n_comp <= n_comp + 1;
        if (w_comp && w_resp) n_both <= n_both + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cntrl_rst = 1'b0; w_start = 1'b0;
        wr_addr = '0; wr_data = '0; wr_strb = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        step(); step();
        chk("rst_ctrl", {axi.awvalid, axi.wvalid, axi.bready, w_comp, w_resp, wr_err, bresp_o}, 0);
        chk("rst_payload", {axi.awaddr, axi.wdata}, 0);
        chk("rst_strb_prot", {axi.wstrb, axi.awprot}, 0);
        reset = 1'b0;
        step();

        // Basic transfer, both readies already high
        w_start = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        axi.awready = 1'b1; axi.wready = 1'b1;
        step();
        chk("basic_valid", {axi.awvalid, axi.wvalid, w_comp}, 3'b110);
        chk("basic_payload", {axi.awaddr, axi.wdata}, 64'h00000010_DEADBEEF);
        chk("basic_strb", axi.wstrb, 4'hF);
        step();
        chk("basic_comp", {axi.awvalid, axi.wvalid, w_comp, axi.bready}, 4'b0011);
        w_start = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        step();
        chk("basic_comp_pulse", {w_comp, w_resp, axi.bready}, 3'b001);
        axi.bvalid = 1'b1; axi.bresp = RESP_OKAY;
        step();
        chk("basic_resp", {w_resp, wr_err, bresp_o, axi.bready}, 5'b10000);
        axi.bvalid = 1'b0;
        step();
        chk("basic_resp_pulse", w_resp, 0);
        repeat (3) step();

        // Skewed: W accepted several cycles after AW; w_start held throughout
        c0 = n_comp; aw0 = n_aw; w0 = n_w;
        w_start = 1'b1; wr_addr = 32'h20; wr_data = 32'h12345678; wr_strb = 4'h3;
        axi.awready = 1'b1; axi.wready = 1'b0;
        step();
        chk("skew_launch", {axi.awvalid, axi.wvalid}, 2'b11);
        step();
        axi.awready = 1'b0;
        chk("skew_aw_done", {axi.awvalid, axi.wvalid, w_comp}, 3'b010);
        wr_data = 32'hFFFFFFFF;
        repeat (4) begin
            step();
            chk("skew_w_hold", {axi.awvalid, axi.wvalid, w_comp}, 3'b010);
        end
        chk("skew_w_stable", axi.wdata, 32'h12345678);
        axi.wready = 1'b1;
        step();
        chk("skew_comp", {axi.awvalid, axi.wvalid, w_comp}, 3'b001);
        axi.wready = 1'b0;
        step();
        chk("skew_comp_once", n_comp - c0, 1);
        chk("skew_beats", {n_aw - aw0, n_w - w0}, {32'd1, 32'd1});

        // Error response, then w_start held high must not relaunch
        axi.bvalid = 1'b1; axi.bresp = RESP_DECERR;
        step();
        chk("err_resp", {w_resp, wr_err, bresp_o}, 4'b1111);
        axi.bvalid = 1'b0;
        repeat (3) begin
            step();
            chk("held_no_relaunch", {axi.awvalid, axi.wvalid, w_resp}, 0);
        end
        chk("held_bresp_kept", {wr_err, bresp_o}, 3'b111);
        w_start = 1'b0;
        step();

        // Relaunch, same-cycle handshakes, then timeout with no bvalid
        aw0 = n_aw; w0 = n_w;
        w_start = 1'b1; wr_addr = 32'h40; wr_data = 32'hCAFEF00D; wr_strb = 4'hC;
        axi.awready = 1'b1; axi.wready = 1'b1;
        step();
        chk("relaunch_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("relaunch_clear", {wr_err, bresp_o}, 0);
        chk("relaunch_addr", axi.awaddr, 32'h40);
        step();
        chk("same_comp", {axi.awvalid, axi.wvalid, w_comp}, 3'b001);
        axi.awready = 1'b0; axi.wready = 1'b0; w_start = 1'b0;
        repeat (7) begin
            step();
            chk("to_wait", {w_resp, axi.bready}, 2'b01);
        end
        step();
        chk("to_resp", {w_resp, wr_err, bresp_o, axi.bready}, 5'b11100);
        chk("same_beats", {n_aw - aw0, n_w - w0}, {32'd1, 32'd1});
        repeat (3) step();

        // Delayed joint readies; cntrl_rst in WAIT_B ignored; bvalid on timeout cycle wins
        w_start = 1'b1; wr_addr = 32'h80; wr_data = 32'h0BADC0DE; wr_strb = 4'h1;
        step();
        chk("late_launch", {axi.awvalid, axi.wvalid}, 2'b11);
        step();
        chk("late_wait", {axi.awvalid, axi.wvalid, w_comp}, 3'b110);
        axi.awready = 1'b1; axi.wready = 1'b1;
        step();
        chk("late_comp", {axi.awvalid, axi.wvalid, w_comp}, 3'b001);
        axi.awready = 1'b0; axi.wready = 1'b0; w_start = 1'b0; cntrl_rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("crst_ignored", {w_resp, axi.bready}, 2'b01);
            if (i == 1) cntrl_rst = 1'b0;
        end
        axi.bvalid = 1'b1; axi.bresp = RESP_EXOKAY;
        step();
        chk("edge_bvalid_wins", {w_resp, wr_err, bresp_o}, 4'b1101);
        axi.bvalid = 1'b0;
        repeat (3) step();

        // Reset while in ADDR_DATA
        w_start = 1'b1; wr_addr = 32'h100; wr_data = 32'h55AA55AA; wr_strb = 4'hF;
        step();
        chk("rst_mid_launch", {axi.awvalid, axi.wvalid}, 2'b11);
        reset = 1'b1;
        step();
        chk("rst_mid_ctrl", {axi.awvalid, axi.wvalid, axi.bready, w_comp, w_resp, wr_err, bresp_o}, 0);
        chk("rst_mid_payload", {axi.awaddr, axi.wdata}, 0);
        reset = 1'b0; w_start = 1'b0;
        step();

        chk("comp_resp_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
